// File: rtl/ara_apb_uart_stub_if.sv
// ============================================================================
// Module      : ara_apb_uart_stub_if
// Description : APB bus bundle for the UART stand-in. Signal names follow
//               the completer's view (_i into the stub, _o out of it).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ara_apb_uart_stub_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 psel_i;
  logic                 penable_i;
  logic                 pwrite_i;
  logic [AddrWidth-1:0] paddr_i;
  logic [DataWidth-1:0] pwdata_i;
  logic [DataWidth-1:0] prdata_o;
  logic                 pready_o;
  logic                 pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

`default_nettype wire

// File: rtl/ara_apb_uart_stub.sv
// ============================================================================
// Module      : ara_apb_uart_stub
// Description : APB completer standing in for the SoC UART. Decodes TXDATA
//               (0x0), STATUS (0x4) and SCRATCH (0x8), buffers TX bytes in a
//               circular FIFO drained by a valid/ready port, and inserts
//               WaitStates access cycles before completion.
//               Optional macro APB_UART_STUB_ERR_EN: a TXDATA write into a
//               full FIFO completes with an error and drops the byte instead
//               of stalling until space frees up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ara_apb_uart_stub #(
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int FifoDepth  = 8,
  parameter int WaitStates = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ara_apb_uart_stub_if.slave apb,
  output logic               tx_valid_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_ready_i
);

  localparam int c_ptr_w = $clog2(FifoDepth);
  localparam int c_cnt_w = $clog2(FifoDepth) + 1;

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_access = 1'b1;

  logic [0:0]           r_state;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           r_addr;
  logic                 r_write;
  logic [DataWidth-1:0] r_scratch;
  logic [7:0]           r_mem [FifoDepth];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_is_tx;
  logic                 w_is_st;
  logic                 w_is_sc;
  logic                 w_err;
  logic                 w_stall;
  logic                 w_done;
  logic                 w_push;
  logic                 w_pop;
  logic [DataWidth-1:0] w_status;
  logic                 w_unused;

  // Only the low nibble of the address is decoded.
  assign w_unused = ^apb.paddr_i[AddrWidth-1:4];

  assign w_full  = (r_count == c_cnt_w'(FifoDepth));
  assign w_empty = (r_count == '0);

  // Decode works on the address/direction captured at setup so outputs never
  // depend combinationally on paddr_i/pwrite_i.
  assign w_is_tx = (r_addr == 4'h0);
  assign w_is_st = (r_addr == 4'h4);
  assign w_is_sc = (r_addr == 4'h8);

`ifdef APB_UART_STUB_ERR_EN
  assign w_err   = !(w_is_tx || w_is_st || w_is_sc) || (r_write && w_is_st)
                   || (r_write && w_is_tx && w_full);
  assign w_stall = 1'b0;
`else
  assign w_err   = !(w_is_tx || w_is_st || w_is_sc) || (r_write && w_is_st);
  assign w_stall = r_write && w_is_tx && w_full;
`endif

  assign w_done = (r_state == c_st_access) && apb.psel_i && apb.penable_i
                  && (r_wait_cnt == 4'd0) && !w_stall;

  // A full FIFO never accepts a byte; with the error option it is dropped.
  assign w_push = w_done && r_write && w_is_tx && !w_full;
  assign w_pop  = tx_valid_o && tx_ready_i;

  assign apb.pready_o  = w_done;
  assign apb.pslverr_o = w_done && w_err;

  // STATUS word: empty, full and occupancy count from start-of-cycle state.
  always_comb begin
    w_status                = '0;
    w_status[0]             = w_empty;
    w_status[1]             = w_full;
    w_status[8 +: c_cnt_w]  = r_count;
  end

  // Read data is driven only on a successful read completion.
  always_comb begin
    apb.prdata_o = '0;
    if (w_done && !r_write && !w_err) begin
      if (w_is_sc)      apb.prdata_o = r_scratch;
      else if (w_is_st) apb.prdata_o = w_status;
    end
  end

  // Transfer FSM: capture request at setup, count wait states, complete or abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= c_st_idle;
      r_wait_cnt <= 4'd0;
      r_addr     <= 4'h0;
      r_write    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (apb.psel_i && !apb.penable_i) begin
            r_state    <= c_st_access;
            r_wait_cnt <= 4'(WaitStates);
            r_addr     <= apb.paddr_i[3:0];
            r_write    <= apb.pwrite_i;
          end
        end
        c_st_access: begin
          if (!apb.psel_i) begin
            r_state    <= c_st_idle;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else if (w_done) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Scratch register updates on a completed write to its offset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scratch <= '0;
    end else if (w_done && r_write && w_is_sc) begin
      r_scratch <= apb.pwdata_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_cnt_w'(1);
      else if (w_pop && !w_push) r_count <= r_count - c_cnt_w'(1);
    end
  end

  // FIFO storage; contents need no reset because tx_data_o is gated by valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= apb.pwdata_i[7:0];
  end

  assign tx_valid_o = !w_empty;
  assign tx_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_ara_apb_uart_stub.sv
// ============================================================================
// Module      : tb_ara_apb_uart_stub
// Description : Directed bench for ara_apb_uart_stub (FifoDepth=4,
//               WaitStates=2). Expectations adapt to APB_UART_STUB_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ara_apb_uart_stub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;

  int n_cmp  = 0;
  int n_fail = 0;

  ara_apb_uart_stub_if #(.AddrWidth(32), .DataWidth(32)) apb ();

  ara_apb_uart_stub #(
    .AddrWidth (32),
    .DataWidth (32),
    .FifoDepth (4),
    .WaitStates(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .apb       (apb),
    .tx_valid_o(tx_valid),
    .tx_data_o (tx_data),
    .tx_ready_i(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns read data, error flag and access-cycle count.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic pop_at_done, output logic [31:0] rdata,
                          output logic err, output int cycles);
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
    apb.paddr_i = addr; apb.pwdata_i = wdata;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    cycles = 1;
    while (!apb.pready_o && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("pready_timeout", {31'd0, apb.pready_o}, 32'd1);
    rdata = apb.prdata_o;
    err   = apb.pslverr_o;
    if (pop_at_done) tx_ready = 1'b1;
    @(posedge clk); #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    if (pop_at_done) tx_ready = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cy;
    logic [7:0]  drain_exp [4];

    rst_n = 1'b0; tx_ready = 1'b0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = '0; apb.pwdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",  {31'd0, apb.pready_o},  32'd0);
    chk("rst_pslverr", {31'd0, apb.pslverr_o}, 32'd0);
    chk("rst_prdata",  apb.prdata_o,           32'd0);
    chk("rst_txvalid", {31'd0, tx_valid},      32'd0);
    chk("rst_txdata",  {24'd0, tx_data},       32'd0);
    rst_n = 1'b1;

    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("status_empty", rd, 32'h1);
    chk("status_empty_cy", cy, 3);

    // Scratch write/read with two wait states.
    apb_xfer(1'b1, 32'h8, 32'hA5, 1'b0, rd, er, cy);
    chk("scr_wr_cy", cy, 3);
    chk("scr_wr_err", {31'd0, er}, 32'd0);
    apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er, cy);
    chk("scr_rd_cy", cy, 3);
    chk("scr_rd_data", rd, 32'hA5);
    chk("scr_rd_err", {31'd0, er}, 32'd0);

    // Fill the FIFO without draining.
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 32'h0, 32'h11 + i, 1'b0, rd, er, cy);
      chk("fill_err", {31'd0, er}, 32'd0);
    end
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("status_full", rd, 32'h402);
    chk("full_head", {24'd0, tx_data}, 32'h11);

`ifdef APB_UART_STUB_ERR_EN
    apb_xfer(1'b1, 32'h0, 32'h15, 1'b0, rd, er, cy);
    chk("ovf_cy", cy, 3);
    chk("ovf_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("ovf_status", rd, 32'h402);
    chk("ovf_head", {24'd0, tx_data}, 32'h11);
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14};
`else
    // Stall until a single pop frees a slot, then complete the push.
    fork
      apb_xfer(1'b1, 32'h0, 32'h15, 1'b0, rd, er, cy);
      begin
        repeat (5) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
      end
    join
    chk("stall_cy", cy, 5);
    chk("stall_err", {31'd0, er}, 32'd0);
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("stall_status", rd, 32'h402);
    chk("stall_head", {24'd0, tx_data}, 32'h12);
    drain_exp = '{8'h12, 8'h13, 8'h14, 8'h15};
`endif

    for (int i = 0; i < 4; i++) pop_chk("drain1", drain_exp[i]);
    chk("drain1_empty", {31'd0, tx_valid}, 32'd0);

    // Push and pop in the same cycle at count 2.
    apb_xfer(1'b1, 32'h0, 32'h11, 1'b0, rd, er, cy);
    apb_xfer(1'b1, 32'h0, 32'h12, 1'b0, rd, er, cy);
    chk("sim_head_before", {24'd0, tx_data}, 32'h11);
    apb_xfer(1'b1, 32'h0, 32'h21, 1'b1, rd, er, cy);
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("sim_status", rd, 32'h200);
    pop_chk("sim_pop0", 8'h12);
    pop_chk("sim_pop1", 8'h21);

    // Another full round across the pointer wrap.
    for (int i = 0; i < 4; i++) apb_xfer(1'b1, 32'h0, 32'h31 + i, 1'b0, rd, er, cy);
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("wrap_status", rd, 32'h402);
    for (int i = 0; i < 4; i++) pop_chk("wrap", 8'(8'h31 + i));

    // Illegal accesses: error, zero data, no side effect.
    apb_xfer(1'b0, 32'hC, 32'h0, 1'b0, rd, er, cy);
    chk("badrd_err", {31'd0, er}, 32'd1);
    chk("badrd_data", rd, 32'h0);
    apb_xfer(1'b1, 32'h4, 32'hFFFF, 1'b0, rd, er, cy);
    chk("stwr_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b1, 32'hC, 32'h5A, 1'b0, rd, er, cy);
    chk("badwr_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("err_status", rd, 32'h1);
    apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er, cy);
    chk("err_scratch", rd, 32'hA5);
    apb_xfer(1'b0, 32'h0, 32'h0, 1'b0, rd, er, cy);
    chk("txrd_data", rd, 32'h0);
    chk("txrd_err", {31'd0, er}, 32'd0);

    // Reset asserted in the completion cycle of a scratch read.
    apb_xfer(1'b1, 32'h0, 32'h77, 1'b0, rd, er, cy);
    @(posedge clk); #1;
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0; apb.paddr_i = 32'h8;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_pready", {31'd0, apb.pready_o}, 32'd1);
    chk("mid_prdata", apb.prdata_o, 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pready",  {31'd0, apb.pready_o},  32'd0);
    chk("arst_prdata",  apb.prdata_o,           32'd0);
    chk("arst_pslverr", {31'd0, apb.pslverr_o}, 32'd0);
    chk("arst_txvalid", {31'd0, tx_valid},      32'd0);
    chk("arst_txdata",  {24'd0, tx_data},       32'd0);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_xfer(1'b0, 32'h4, 32'h0, 1'b0, rd, er, cy);
    chk("post_rst_status", rd, 32'h1);
    apb_xfer(1'b0, 32'h8, 32'h0, 1'b0, rd, er, cy);
    chk("post_rst_scratch", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
